multicycle_ctrl_fsm: RTL

- Main control state machine for the multicycle RV32I core.
- Sequences one instruction over 3–5 states (fetch, decode, execute, memory, writeback) through the shared ALU, register file and unified memory port.
- Drives ALUOp into the ALU decoder, plus all mux selects and write enables.
- Stalls on a memory-ready handshake; counts retired instructions.

---
 rtl/core_ctrl_pkg.sv | 67 ++++++
 rtl/multicycle_ctrl_fsm_if.sv | 35 +++
 rtl/ctrl_out_decode.sv | 84 ++++++++
 rtl/multicycle_ctrl_fsm.sv | 104 ++++++++++
 4 files changed

// File: rtl/core_ctrl_pkg.sv
// Shared types and constants for the multicycle RV32I control path.
package core_ctrl_pkg;

    // Controller states (4-bit; encodings 11-15 are unused)
    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXEC_R   = 4'd6,
        ST_EXEC_I   = 4'd7,
        ST_ALUWB    = 4'd8,
        ST_JAL      = 4'd9,
        ST_BEQ      = 4'd10
    } ctrl_state_t;

    // Supported opcodes
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    // ALU decoder control
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Result mux
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    // ALU A mux
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALU B mux
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Bundle of all decoded control outputs
    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       illegal_instr;
    } ctrl_out_t;

    // True for every opcode the controller knows how to sequence
    function automatic logic is_legal_op(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
               (op == OP_I)  || (op == OP_JAL) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Controller <-> datapath signal bundle. The controller uses the master
// modport; the datapath (or a testbench) uses the slave modport.
interface multicycle_ctrl_fsm_if #(
    parameter int CNT_W = 32
) ();
    logic [6:0]       op;
    logic             zero;
    logic             mem_ready;
    logic             pc_write;
    logic             adr_src;
    logic             mem_write;
    logic             ir_write;
    logic [1:0]       result_src;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             reg_write;
    logic             illegal_instr;
    logic [CNT_W-1:0] retired;
    logic [3:0]       state_dbg;

    modport master (
        input  op, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_op, reg_write, illegal_instr,
               retired, state_dbg
    );

    modport slave (
        output op, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_op, reg_write, illegal_instr,
               retired, state_dbg
    );
endinterface

// File: rtl/ctrl_out_decode.sv
// Pure combinational state -> control-output table. Only FETCH, DECODE
// and BEQ look at inputs (mem_ready, op, zero respectively).
module ctrl_out_decode
    import core_ctrl_pkg::*;
(
    input  ctrl_state_t state,
    input  logic [6:0]  op,
    input  logic        zero,
    input  logic        mem_ready,
    output ctrl_out_t   ctrl
);

    // Decode the current state into mux selects and enables; unlisted signals stay 0
    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.adr_src    = 1'b0;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALURES;
                // Fetch completes only in the mem_ready cycle, so IR/PC load once per fetch
                ctrl.ir_write   = mem_ready;
                ctrl.pc_write   = mem_ready;
            end
            ST_DECODE: begin
                ctrl.alu_src_a     = SRCA_OLDPC;
                ctrl.alu_src_b     = SRCB_IMM;
                ctrl.alu_op        = ALUOP_ADD;
                ctrl.illegal_instr = !is_legal_op(op);
            end
            ST_MEMADR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEMREAD: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.adr_src    = 1'b1;
            end
            ST_MEMWB: begin
                ctrl.result_src = RES_DATA;
                ctrl.reg_write  = 1'b1;
            end
            ST_MEMWRITE: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.adr_src    = 1'b1;
                ctrl.mem_write  = 1'b1;
            end
            ST_EXEC_R: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_RS2;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            ST_EXEC_I: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            ST_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
            end
            ST_JAL: begin
                // PC <- branch target computed in DECODE; ALU forms OldPC+4 for the link
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_write   = 1'b1;
            end
            ST_BEQ: begin
                ctrl.alu_src_a  = SRCA_RS1;
                ctrl.alu_src_b  = SRCB_RS2;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_write   = zero;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main multicycle RV32I control FSM: state register, next-state logic,
// retired-instruction counter, and reset gating of the decoded outputs.
module multicycle_ctrl_fsm
    import core_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    multicycle_ctrl_fsm_if.master bus
);

    ctrl_state_t      state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire_evt;
    ctrl_out_t        dec;

    // State register; reset abandons any instruction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_FETCH;
        else     state_q <= state_d;
    end

    // Retired-instruction counter, wraps naturally at 2^CNT_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst) retired_q <= '0;
        else     retired_q <= retired_d;
    end

    // Next-state selection and retire detection
    always_comb begin
        state_d    = state_q;
        retire_evt = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (bus.mem_ready) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_R:         state_d = ST_EXEC_R;
                    OP_I:         state_d = ST_EXEC_I;
                    OP_JAL:       state_d = ST_JAL;
                    OP_BEQ:       state_d = ST_BEQ;
                    default:      state_d = ST_FETCH;
                endcase
            end
            ST_MEMADR: begin
                state_d = (bus.op == OP_LW) ? ST_MEMREAD : ST_MEMWRITE;
            end
            ST_MEMREAD: begin
                if (bus.mem_ready) state_d = ST_MEMWB;
            end
            ST_MEMWB: begin
                state_d    = ST_FETCH;
                retire_evt = 1'b1;
            end
            ST_MEMWRITE: begin
                if (bus.mem_ready) begin
                    state_d    = ST_FETCH;
                    retire_evt = 1'b1;
                end
            end
            ST_EXEC_R: state_d = ST_ALUWB;
            ST_EXEC_I: state_d = ST_ALUWB;
            ST_ALUWB: begin
                state_d    = ST_FETCH;
                retire_evt = 1'b1;
            end
            ST_JAL: state_d = ST_ALUWB;
            ST_BEQ: begin
                state_d    = ST_FETCH;
                retire_evt = 1'b1;
            end
            default: state_d = ST_FETCH;
        endcase
        retired_d = retire_evt ? (retired_q + CNT_W'(1)) : retired_q;
    end

    ctrl_out_decode u_decode (
        .state     (state_q),
        .op        (bus.op),
        .zero      (bus.zero),
        .mem_ready (bus.mem_ready),
        .ctrl      (dec)
    );

    // Drive outputs; write enables and the illegal pulse are held low during reset
    always_comb begin
        bus.pc_write      = dec.pc_write & ~rst;
        bus.ir_write      = dec.ir_write & ~rst;
        bus.reg_write     = dec.reg_write & ~rst;
        bus.mem_write     = dec.mem_write & ~rst;
        bus.illegal_instr = dec.illegal_instr & ~rst;
        bus.adr_src       = dec.adr_src;
        bus.result_src    = dec.result_src;
        bus.alu_src_a     = dec.alu_src_a;
        bus.alu_src_b     = dec.alu_src_b;
        bus.alu_op        = dec.alu_op;
        bus.retired       = retired_q;
        bus.state_dbg     = state_q;
    end

endmodule
